// File: rtl/sram_pkg.sv
// Shared constants, state encoding and helpers for the SRAM chip model.
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sram_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sram_chip_model_if.sv
// Address and active-low strobe pins of the SRAM bus; data pins stay a top-level inout.
interface sram_chip_model_if;
    import sram_pkg::*;

    logic [SRAM_ADDR_W-1:0] SRAM_ADDR;
    logic                   SRAM_UB_EN;
    logic                   SRAM_LB_EN;
    logic                   SRAM_WE_EN;
    logic                   SRAM_CE_EN;
    logic                   SRAM_OE_EN;

    modport master (
        output SRAM_ADDR, SRAM_UB_EN, SRAM_LB_EN, SRAM_WE_EN, SRAM_CE_EN, SRAM_OE_EN
    );

    modport slave (
        input SRAM_ADDR, SRAM_UB_EN, SRAM_LB_EN, SRAM_WE_EN, SRAM_CE_EN, SRAM_OE_EN
    );

endinterface

// File: rtl/sram_rd_pipe.sv
// Read-latency delay line: RD_LAT stages of data plus valid, valid bits async-cleared.
module sram_rd_pipe #(
    parameter int RD_LAT = 1,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT:1]             vld_pipe;
    logic [RD_LAT:1][DATA_W-1:0] dat_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_vld;
            for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Data needs no reset: it is only observed behind its valid bit.
    always_ff @(posedge clk) begin
        dat_pipe[1] <= in_data;
        for (int i = 2; i <= RD_LAT; i++) dat_pipe[i] <= dat_pipe[i-1];
    end

    assign out_vld  = vld_pipe[RD_LAT];
    assign out_data = dat_pipe[RD_LAT];

endmodule

// File: rtl/sram_chip_model.sv
// Asynchronous-SRAM chip model: self-zeroing array, byte-lane writes, pipelined reads,
// transaction counters and a sticky address-error flag.
module sram_chip_model import sram_pkg::*; #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_chip_model_if.slave       bus,
    inout  wire [SRAM_DATA_W-1:0]  SRAM_DQ,
    output logic                   init_busy,
    output logic [15:0]            wr_count,
    output logic [15:0]            rd_count,
    output logic                   addr_err
);

    localparam int DEPTH = 1 << ADDR_W;

    sram_state_e             state, state_nxt;
    logic [ADDR_W-1:0]       init_ptr;
    logic [SRAM_DATA_W-1:0]  mem [0:DEPTH-1];

    logic                    sel, addr_oor;
    logic [ADDR_W-1:0]       addr_w;
    logic                    wr_cyc, rd_cyc;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_wa;
    logic [SRAM_DATA_W-1:0]  mem_wd;
    logic [1:0]              mem_be;

    logic                    prev_rd;
    logic [SRAM_ADDR_W-1:0]  prev_addr;
    logic                    pipe_vld;
    logic [SRAM_DATA_W-1:0]  pipe_q;
    logic                    drv_ub, drv_lb;

    assign sel      = !bus.SRAM_CE_EN;
    assign addr_w   = bus.SRAM_ADDR[ADDR_W-1:0];
    assign addr_oor = (bus.SRAM_ADDR >> ADDR_W) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_ptr == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
    end

    // INIT owns the single write port; in RUN the bus does.
    always_comb begin
        init_busy = (state == ST_INIT);
        wr_cyc    = 1'b0;
        rd_cyc    = 1'b0;
        mem_we    = 1'b0;
        mem_wa    = addr_w;
        mem_wd    = SRAM_DQ;
        mem_be    = 2'b00;
        case (state)
            ST_INIT: begin
                mem_we = 1'b1;
                mem_wa = init_ptr;
                mem_wd = '0;
                mem_be = 2'b11;
            end
            ST_RUN: begin
                wr_cyc = sel && !bus.SRAM_WE_EN;
                rd_cyc = sel && bus.SRAM_WE_EN && !bus.SRAM_OE_EN;
                mem_we = wr_cyc;
                mem_be = {!bus.SRAM_UB_EN, !bus.SRAM_LB_EN};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    init_ptr <= '0;
        else if (state == ST_INIT)  init_ptr <= init_ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (mem_be[1]) mem[mem_wa][15:8] <= mem_wd[15:8];
            if (mem_be[0]) mem[mem_wa][7:0]  <= mem_wd[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count  <= '0;
            rd_count  <= '0;
            addr_err  <= 1'b0;
            prev_rd   <= 1'b0;
            prev_addr <= '0;
        end else begin
            if (wr_cyc) wr_count <= sat_inc16(wr_count);
            // A held read on one address is a single transaction.
            if (rd_cyc && (!prev_rd || bus.SRAM_ADDR != prev_addr))
                rd_count <= sat_inc16(rd_count);
            if (sel && (addr_oor || (state == ST_INIT && !bus.SRAM_WE_EN)))
                addr_err <= 1'b1;
            prev_rd   <= rd_cyc;
            prev_addr <= bus.SRAM_ADDR;
        end
    end

    sram_rd_pipe #(.RD_LAT(RD_LAT), .DATA_W(SRAM_DATA_W)) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_cyc),
        .in_data  (mem[addr_w]),
        .out_vld  (pipe_vld),
        .out_data (pipe_q)
    );

    assign drv_ub = sel && !bus.SRAM_OE_EN && bus.SRAM_WE_EN && !bus.SRAM_UB_EN
                    && state == ST_RUN && pipe_vld;
    assign drv_lb = sel && !bus.SRAM_OE_EN && bus.SRAM_WE_EN && !bus.SRAM_LB_EN
                    && state == ST_RUN && pipe_vld;

    assign SRAM_DQ[15:8] = drv_ub ? pipe_q[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = drv_lb ? pipe_q[7:0]  : 8'hzz;

endmodule
